// File: rtl/settings_batch_handler_if.sv
// Control, buffer-read and settings bus of settings_batch_handler.
// SETTINGS_WRITEBACK_EN adds the buffer write-back port.
interface settings_batch_handler_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 3
);
  logic              i_start;
  logic              i_clear_err;
  logic              o_busy;
  logic              o_done;
  logic              o_error;
  logic [2:0]        o_err_code;
  logic [IDX_W-1:0]  o_err_index;
  logic              o_buf_rd_en;
  logic [ADDR_W-1:0] o_buf_rd_addr;
  logic [DATA_W-1:0] i_buf_rd_data;
  logic              o_settings_wr_en;
  logic [DATA_W-1:0] o_settings_max_row;
  logic [DATA_W-1:0] o_settings_max_col;
  logic [DATA_W-1:0] o_settings_data_min;
  logic [DATA_W-1:0] o_settings_data_max;
  logic [DATA_W-1:0] o_settings_countdown;
`ifdef SETTINGS_WRITEBACK_EN
  logic              o_buf_wr_en;
  logic [ADDR_W-1:0] o_buf_wr_addr;
  logic [DATA_W-1:0] o_buf_wr_data;

  modport master (
    input  i_start, i_clear_err, i_buf_rd_data,
    output o_busy, o_done, o_error, o_err_code, o_err_index,
           o_buf_rd_en, o_buf_rd_addr, o_settings_wr_en,
           o_settings_max_row, o_settings_max_col, o_settings_data_min,
           o_settings_data_max, o_settings_countdown,
           o_buf_wr_en, o_buf_wr_addr, o_buf_wr_data
  );
  modport slave (
    output i_start, i_clear_err, i_buf_rd_data,
    input  o_busy, o_done, o_error, o_err_code, o_err_index,
           o_buf_rd_en, o_buf_rd_addr, o_settings_wr_en,
           o_settings_max_row, o_settings_max_col, o_settings_data_min,
           o_settings_data_max, o_settings_countdown,
           o_buf_wr_en, o_buf_wr_addr, o_buf_wr_data
  );
`else
  modport master (
    input  i_start, i_clear_err, i_buf_rd_data,
    output o_busy, o_done, o_error, o_err_code, o_err_index,
           o_buf_rd_en, o_buf_rd_addr, o_settings_wr_en,
           o_settings_max_row, o_settings_max_col, o_settings_data_min,
           o_settings_data_max, o_settings_countdown
  );
  modport slave (
    output i_start, i_clear_err, i_buf_rd_data,
    input  o_busy, o_done, o_error, o_err_code, o_err_index,
           o_buf_rd_en, o_buf_rd_addr, o_settings_wr_en,
           o_settings_max_row, o_settings_max_col, o_settings_data_min,
           o_settings_data_max, o_settings_countdown
  );
`endif
endinterface

// File: rtl/settings_batch_handler.sv
// Reads a batch of cmd/data pairs, validates into shadows, commits atomically.
// Optional SETTINGS_WRITEBACK_EN writes committed settings back to the buffer.
module settings_batch_handler #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned MAX_CMDS   = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned DIM_MAX    = 32,
  parameter int unsigned DATA_LIMIT = 65535,
  parameter int unsigned CD_MIN     = 5,
  parameter int unsigned CD_MAX     = 15,
  parameter int unsigned WB_BASE    = 64
) (
  input logic                     clk,
  input logic                     rst,
  settings_batch_handler_if.master bus
);
  localparam int unsigned IDX_W = (MAX_CMDS > 1) ? $clog2(MAX_CMDS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_CMDS + 1);

  localparam logic [DATA_W-1:0] LIM_HI = DATA_W'(DATA_LIMIT);
  localparam logic [DATA_W-1:0] LIM_LO = ~LIM_HI;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RD_CNT    = 4'd1;
  localparam logic [3:0] S_RD_CMD    = 4'd2;
  localparam logic [3:0] S_RD_DATA   = 4'd3;
  localparam logic [3:0] S_CHECK     = 4'd4;
  localparam logic [3:0] S_XCHK      = 4'd5;
  localparam logic [3:0] S_COMMIT    = 4'd6;
`ifdef SETTINGS_WRITEBACK_EN
  localparam logic [3:0] S_WRITEBACK = 4'd7;
`endif
  localparam logic [3:0] S_DONE      = 4'd8;
  localparam logic [3:0] S_ERR       = 4'd9;

  // Reject configurations the read/write-back sequencing cannot honour
  if (RD_LATENCY > 1 || (WB_BASE + 5) > (32'd1 << ADDR_W)) begin : g_bad_cfg
    $error("settings_batch_handler: unsupported RD_LATENCY or WB_BASE");
  end

  logic [3:0]        r_state, w_state;
  logic              r_wait, w_wait;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_error, w_error;
  logic [2:0]        r_err_code, w_err_code;
  logic [IDX_W-1:0]  r_err_index, w_err_index;
  logic              r_rd_en, w_rd_en;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr;
  logic              r_set_wr, w_set_wr;
  logic [CNT_W-1:0]  r_num, w_num;
  logic [IDX_W-1:0]  r_idx, w_idx;
  logic [2:0]        r_cmd, w_cmd;
  logic [DATA_W-1:0] r_data, w_data;
  logic [DATA_W-1:0] r_set_row, r_set_col, r_set_min, r_set_max, r_set_cd;
  logic [DATA_W-1:0] w_set_row, w_set_col, w_set_min, w_set_max, w_set_cd;
  logic [DATA_W-1:0] r_sh_row, r_sh_col, r_sh_min, r_sh_max, r_sh_cd;
  logic [DATA_W-1:0] w_sh_row, w_sh_col, w_sh_min, w_sh_max, w_sh_cd;
`ifdef SETTINGS_WRITEBACK_EN
  logic [2:0]        r_wb_cnt, w_wb_cnt;
  logic              r_wr_en, w_wr_en;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr;
  logic [DATA_W-1:0] r_wr_data, w_wr_data;
`endif

  logic w_sample, w_dim_ok, w_lim_ok, w_cd_ok, w_last;

  // Read data is valid RD_LATENCY cycles after the strobe cycle
  assign w_sample = (r_wait == 1'(RD_LATENCY));
  assign w_dim_ok = (r_data >= DATA_W'(1)) && (r_data <= DATA_W'(DIM_MAX));
  assign w_lim_ok = ($signed(r_data) >= $signed(LIM_LO)) && ($signed(r_data) <= $signed(LIM_HI));
  assign w_cd_ok  = (r_data >= DATA_W'(CD_MIN)) && (r_data <= DATA_W'(CD_MAX));
  assign w_last   = ((CNT_W'(r_idx) + CNT_W'(1)) == r_num);

  always_comb begin
    w_state     = r_state;
    w_wait      = r_wait + 1'b1;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_error     = r_error;
    w_err_code  = r_err_code;
    w_err_index = r_err_index;
    w_rd_en     = 1'b0;
    w_rd_addr   = r_rd_addr;
    w_set_wr    = 1'b0;
    w_num       = r_num;
    w_idx       = r_idx;
    w_cmd       = r_cmd;
    w_data      = r_data;
    w_set_row   = r_set_row;
    w_set_col   = r_set_col;
    w_set_min   = r_set_min;
    w_set_max   = r_set_max;
    w_set_cd    = r_set_cd;
    w_sh_row    = r_sh_row;
    w_sh_col    = r_sh_col;
    w_sh_min    = r_sh_min;
    w_sh_max    = r_sh_max;
    w_sh_cd     = r_sh_cd;
`ifdef SETTINGS_WRITEBACK_EN
    w_wb_cnt    = r_wb_cnt;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_wr_addr;
    w_wr_data   = r_wr_data;
`endif

    case (r_state)
      S_IDLE: begin
        if (bus.i_start && !r_error) begin
          w_state   = S_RD_CNT;
          w_busy    = 1'b1;
          w_rd_en   = 1'b1;
          w_rd_addr = ADDR_W'(BASE_ADDR);
          w_wait    = 1'b0;
          w_sh_row  = r_set_row;
          w_sh_col  = r_set_col;
          w_sh_min  = r_set_min;
          w_sh_max  = r_set_max;
          w_sh_cd   = r_set_cd;
        end
      end
      S_RD_CNT: begin
        if (w_sample) begin
          if (bus.i_buf_rd_data == '0 || bus.i_buf_rd_data > DATA_W'(MAX_CMDS)) begin
            w_state     = S_ERR;
            w_error     = 1'b1;
            w_busy      = 1'b0;
            w_err_code  = 3'd1;
            w_err_index = '0;
          end else begin
            w_num     = CNT_W'(bus.i_buf_rd_data);
            w_idx     = '0;
            w_state   = S_RD_CMD;
            w_rd_en   = 1'b1;
            w_rd_addr = r_rd_addr + ADDR_W'(1);
            w_wait    = 1'b0;
          end
        end
      end
      S_RD_CMD: begin
        if (w_sample) begin
          // Unknown commands collapse to 0 so only 3 bits are held
          w_cmd     = (bus.i_buf_rd_data >= DATA_W'(1) && bus.i_buf_rd_data <= DATA_W'(5))
                      ? 3'(bus.i_buf_rd_data) : 3'd0;
          w_state   = S_RD_DATA;
          w_rd_en   = 1'b1;
          w_rd_addr = r_rd_addr + ADDR_W'(1);
          w_wait    = 1'b0;
        end
      end
      S_RD_DATA: begin
        if (w_sample) begin
          w_data  = bus.i_buf_rd_data;
          w_state = S_CHECK;
        end
      end
      S_CHECK: begin
        w_state = w_last ? S_XCHK : S_RD_CMD;
        case (r_cmd)
          3'd1: if (w_dim_ok) w_sh_row = r_data; else w_err_code = 3'd3;
          3'd2: if (w_dim_ok) w_sh_col = r_data; else w_err_code = 3'd3;
          3'd3: if (w_lim_ok) w_sh_min = r_data; else w_err_code = 3'd3;
          3'd4: if (w_lim_ok) w_sh_max = r_data; else w_err_code = 3'd3;
          3'd5: if (w_cd_ok)  w_sh_cd  = r_data; else w_err_code = 3'd3;
          default: w_err_code = 3'd2;
        endcase
        if (w_err_code != 3'd0) begin
          w_state     = S_ERR;
          w_error     = 1'b1;
          w_busy      = 1'b0;
          w_err_index = r_idx;
        end else if (!w_last) begin
          w_idx     = r_idx + IDX_W'(1);
          w_rd_en   = 1'b1;
          w_rd_addr = r_rd_addr + ADDR_W'(1);
          w_wait    = 1'b0;
        end
      end
      S_XCHK: begin
        if ($signed(r_sh_min) > $signed(r_sh_max)) begin
          w_state     = S_ERR;
          w_error     = 1'b1;
          w_busy      = 1'b0;
          w_err_code  = 3'd4;
          w_err_index = '0;
        end else begin
          w_state   = S_COMMIT;
          w_set_wr  = 1'b1;
          w_set_row = r_sh_row;
          w_set_col = r_sh_col;
          w_set_min = r_sh_min;
          w_set_max = r_sh_max;
          w_set_cd  = r_sh_cd;
        end
      end
      S_COMMIT: begin
`ifdef SETTINGS_WRITEBACK_EN
        w_state   = S_WRITEBACK;
        w_wr_en   = 1'b1;
        w_wr_addr = ADDR_W'(WB_BASE);
        w_wr_data = r_set_row;
        w_wb_cnt  = 3'd1;
`else
        w_state = S_DONE;
        w_done  = 1'b1;
        w_busy  = 1'b0;
`endif
      end
`ifdef SETTINGS_WRITEBACK_EN
      S_WRITEBACK: begin
        // r_wb_cnt counts words already presented on the write port
        if (r_wb_cnt == 3'd5) begin
          w_state = S_DONE;
          w_done  = 1'b1;
          w_busy  = 1'b0;
        end else begin
          w_wr_en   = 1'b1;
          w_wr_addr = ADDR_W'(WB_BASE) + ADDR_W'(r_wb_cnt);
          w_wb_cnt  = r_wb_cnt + 3'd1;
          case (r_wb_cnt)
            3'd1:    w_wr_data = r_set_col;
            3'd2:    w_wr_data = r_set_min;
            3'd3:    w_wr_data = r_set_max;
            default: w_wr_data = r_set_cd;
          endcase
        end
      end
`endif
      S_DONE: w_state = S_IDLE;
      S_ERR: begin
        if (bus.i_clear_err) begin
          w_state     = S_IDLE;
          w_error     = 1'b0;
          w_err_code  = 3'd0;
          w_err_index = '0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= 3'd0;
      r_err_index <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= ADDR_W'(BASE_ADDR);
      r_set_wr    <= 1'b0;
      r_num       <= '0;
      r_idx       <= '0;
      r_cmd       <= 3'd0;
      r_data      <= '0;
      r_set_row   <= DATA_W'(DIM_MAX);
      r_set_col   <= DATA_W'(DIM_MAX);
      r_set_min   <= '0;
      r_set_max   <= DATA_W'(DATA_LIMIT);
      r_set_cd    <= DATA_W'(CD_MAX);
      r_sh_row    <= DATA_W'(DIM_MAX);
      r_sh_col    <= DATA_W'(DIM_MAX);
      r_sh_min    <= '0;
      r_sh_max    <= DATA_W'(DATA_LIMIT);
      r_sh_cd     <= DATA_W'(CD_MAX);
`ifdef SETTINGS_WRITEBACK_EN
      r_wb_cnt    <= 3'd0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= ADDR_W'(WB_BASE);
      r_wr_data   <= '0;
`endif
    end else begin
      r_state     <= w_state;
      r_wait      <= w_wait;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_error     <= w_error;
      r_err_code  <= w_err_code;
      r_err_index <= w_err_index;
      r_rd_en     <= w_rd_en;
      r_rd_addr   <= w_rd_addr;
      r_set_wr    <= w_set_wr;
      r_num       <= w_num;
      r_idx       <= w_idx;
      r_cmd       <= w_cmd;
      r_data      <= w_data;
      r_set_row   <= w_set_row;
      r_set_col   <= w_set_col;
      r_set_min   <= w_set_min;
      r_set_max   <= w_set_max;
      r_set_cd    <= w_set_cd;
      r_sh_row    <= w_sh_row;
      r_sh_col    <= w_sh_col;
      r_sh_min    <= w_sh_min;
      r_sh_max    <= w_sh_max;
      r_sh_cd     <= w_sh_cd;
`ifdef SETTINGS_WRITEBACK_EN
      r_wb_cnt    <= w_wb_cnt;
      r_wr_en     <= w_wr_en;
      r_wr_addr   <= w_wr_addr;
      r_wr_data   <= w_wr_data;
`endif
    end
  end

  assign bus.o_busy               = r_busy;
  assign bus.o_done               = r_done;
  assign bus.o_error              = r_error;
  assign bus.o_err_code           = r_err_code;
  assign bus.o_err_index          = r_err_index;
  assign bus.o_buf_rd_en          = r_rd_en;
  assign bus.o_buf_rd_addr        = r_rd_addr;
  assign bus.o_settings_wr_en     = r_set_wr;
  assign bus.o_settings_max_row   = r_set_row;
  assign bus.o_settings_max_col   = r_set_col;
  assign bus.o_settings_data_min  = r_set_min;
  assign bus.o_settings_data_max  = r_set_max;
  assign bus.o_settings_countdown = r_set_cd;
`ifdef SETTINGS_WRITEBACK_EN
  assign bus.o_buf_wr_en          = r_wr_en;
  assign bus.o_buf_wr_addr        = r_wr_addr;
  assign bus.o_buf_wr_data        = r_wr_data;
`endif
endmodule
